// File: rtl/game_pkg.sv
// Shared types and digit-range helpers for the digit-guessing game.
package game_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MIN = DIGIT_W'(1);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] nibble);
    return (nibble >= DIGIT_MIN) && (nibble <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/digit_select.sv
// Combinational nibble mux over a packed answer word; index 0 is the most
// significant nibble. Also used by the display logic.
module digit_select
  import game_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic [DIGIT_W*DIGITS-1:0]  word_i,
  input  logic [$clog2(DIGITS)-1:0]  index_i,
  output logic [DIGIT_W-1:0]         digit_o
);

  assign digit_o = word_i[(DIGITS - 1 - int'(index_i)) * DIGIT_W +: DIGIT_W];

endmodule

// File: rtl/answer_checker.sv
// Answer-request handshake plus per-digit guess scoring for one game round.
// Optional hint output enabled with `define ANSWER_CHECKER_HINT_EN.
module answer_checker
  import game_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int MAX_MISS    = 3,
  parameter int REQ_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          write_enable,
  input  logic [DIGIT_W*DIGITS-1:0]     answer_in,
  input  logic                          guess_valid,
  input  logic [DIGIT_W-1:0]            guess_digit,
  output logic                          change_answer,
  output logic                          playing,
  output logic [$clog2(DIGITS)-1:0]     digit_index,
  output logic [$clog2(DIGITS+1)-1:0]   correct_count,
  output logic [$clog2(MAX_MISS+1)-1:0] miss_count,
  output logic                          round_done,
  output logic                          round_win,
  output logic                          round_fail,
  output logic                          hint_high
);

  localparam int IDX_W  = $clog2(DIGITS);
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int MISS_W = $clog2(MAX_MISS + 1);
  localparam int TMO_W  = $clog2(REQ_TIMEOUT);

  state_e                    state_q, state_d;
  logic [DIGIT_W*DIGITS-1:0] answer_q, answer_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          correct_q, correct_d;
  logic [MISS_W-1:0]         miss_q, miss_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic                      change_q, change_d;
  logic                      done_q, done_d;
  logic                      win_q, win_d;
  logic                      fail_q, fail_d;

  logic [DIGIT_W-1:0] cur_digit;
  logic               answer_ok;
  logic               begin_round;
  logic               guess_counted;
  logic               guess_hit;

  digit_select #(.DIGITS(DIGITS)) u_digit_select (
    .word_i  (answer_q),
    .index_i (idx_q),
    .digit_o (cur_digit)
  );

  always_comb begin
    answer_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_ok(answer_in[i*DIGIT_W +: DIGIT_W])) answer_ok = 1'b0;
    end
  end

  // start is ignored while a request is already outstanding.
  assign begin_round   = start && (state_q != REQ);
  assign guess_counted = (state_q == PLAY) && !start && guess_valid && digit_ok(guess_digit);
  assign guess_hit     = guess_counted && (guess_digit == cur_digit);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    answer_d  = answer_q;
    idx_d     = idx_q;
    correct_d = correct_q;
    miss_d    = miss_q;
    tmo_d     = tmo_q;
    change_d  = 1'b0;
    done_d    = 1'b0;
    win_d     = win_q;
    fail_d    = fail_q;

    if (begin_round) begin
      state_d   = REQ;
      change_d  = 1'b1;
      tmo_d     = '0;
      idx_d     = '0;
      correct_d = '0;
      miss_d    = '0;
      win_d     = 1'b0;
      fail_d    = 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          if (write_enable) begin
            answer_d = answer_in;
            tmo_d    = '0;
            if (answer_ok) state_d  = PLAY;
            else           change_d = 1'b1;
          end else if (tmo_q == TMO_W'(REQ_TIMEOUT - 1)) begin
            tmo_d    = '0;
            change_d = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        PLAY: begin
          if (guess_hit) begin
            if (correct_q != CNT_W'(DIGITS)) correct_d = correct_q + CNT_W'(1);
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(DIGITS - 1)) begin
              state_d = DONE;
              win_d   = 1'b1;
              done_d  = 1'b1;
            end
          end else if (guess_counted) begin
            miss_d = miss_q + MISS_W'(1);
            if (miss_q == MISS_W'(MAX_MISS - 1)) begin
              state_d = DONE;
              fail_d  = 1'b1;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      answer_q  <= '0;
      idx_q     <= '0;
      correct_q <= '0;
      miss_q    <= '0;
      tmo_q     <= '0;
      change_q  <= 1'b0;
      done_q    <= 1'b0;
      win_q     <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      answer_q  <= answer_d;
      idx_q     <= idx_d;
      correct_q <= correct_d;
      miss_q    <= miss_d;
      tmo_q     <= tmo_d;
      change_q  <= change_d;
      done_q    <= done_d;
      win_q     <= win_d;
      fail_q    <= fail_d;
    end
  end

`ifdef ANSWER_CHECKER_HINT_EN
  logic hint_q;

  always_ff @(posedge clk) begin
    if (rst || begin_round) hint_q <= 1'b0;
    else if (guess_hit)     hint_q <= 1'b0;
    else if (guess_counted) hint_q <= (cur_digit > guess_digit);
  end

  assign hint_high = hint_q;
`else
  assign hint_high = 1'b0;
`endif

  assign change_answer = change_q;
  assign playing       = (state_q == PLAY);
  assign digit_index   = idx_q;
  assign correct_count = correct_q;
  assign miss_count    = miss_q;
  assign round_done    = done_q;
  assign round_win     = win_q;
  assign round_fail    = fail_q;

endmodule

// File: tb/tb_answer_checker.sv
// Scenario-per-task bench for answer_checker; round outcomes go through a
// scoreboard queue that is popped whenever round_done pulses.
module tb_answer_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        write_enable;
  logic [31:0] answer_in;
  logic        guess_valid;
  logic [3:0]  guess_digit;
  logic        change_answer;
  logic        playing;
  logic [2:0]  digit_index;
  logic [3:0]  correct_count;
  logic [1:0]  miss_count;
  logic        round_done;
  logic        round_win;
  logic        round_fail;
  logic        hint_high;

  int checks = 0;
  int errors = 0;

`ifdef ANSWER_CHECKER_HINT_EN
  localparam bit HINT_EN = 1'b1;
`else
  localparam bit HINT_EN = 1'b0;
`endif

  typedef struct {
    logic       win;
    logic       fail;
    logic [3:0] correct;
    logic [1:0] miss;
  } round_t;

  round_t exp_q[$];

  answer_checker dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .write_enable  (write_enable),
    .answer_in     (answer_in),
    .guess_valid   (guess_valid),
    .guess_digit   (guess_digit),
    .change_answer (change_answer),
    .playing       (playing),
    .digit_index   (digit_index),
    .correct_count (correct_count),
    .miss_count    (miss_count),
    .round_done    (round_done),
    .round_win     (round_win),
    .round_fail    (round_fail),
    .hint_high     (hint_high)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard consumer: every round_done pulse must match a queued outcome.
  always @(posedge clk) begin
    round_t e;
    #1;
    if (round_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL round_done_unexpected: got pulse, expected none");
      end else begin
        e = exp_q.pop_front();
        if ({round_win, round_fail, correct_count, miss_count} !==
            {e.win, e.fail, e.correct, e.miss}) begin
          errors++;
          $display("FAIL round_outcome: got win=%b fail=%b correct=%0d miss=%0d, expected win=%b fail=%b correct=%0d miss=%0d",
                   round_win, round_fail, correct_count, miss_count,
                   e.win, e.fail, e.correct, e.miss);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic give_answer(input logic [31:0] w);
    write_enable = 1'b1;
    answer_in    = w;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic guess(input logic [3:0] d);
    guess_valid = 1'b1;
    guess_digit = d;
    tick();
    guess_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({change_answer, playing, digit_index, correct_count, miss_count,
         round_done, round_win, round_fail, hint_high} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {change_answer, playing, digit_index, correct_count, miss_count,
                round_done, round_win, round_fail, hint_high});
    end
  endtask

  task automatic test_win();
    do_start();
    checks++;
    if (change_answer !== 1'b1 || playing !== 1'b0) begin
      errors++;
      $display("FAIL win_req_entry: got change=%b playing=%b, expected 1 0", change_answer, playing);
    end
    tick();
    checks++;
    if (change_answer !== 1'b0) begin
      errors++;
      $display("FAIL win_change_single: got %b, expected 0", change_answer);
    end
    exp_q.push_back('{win: 1'b1, fail: 1'b0, correct: 4'd8, miss: 2'd0});
    give_answer(32'h1234_5678);
    checks++;
    if (playing !== 1'b1 || digit_index !== 3'd0) begin
      errors++;
      $display("FAIL win_play_entry: got playing=%b idx=%0d, expected 1 0", playing, digit_index);
    end
    for (int i = 1; i <= 8; i++) begin
      guess(4'(i));
      if (i < 8) begin
        checks++;
        if (correct_count !== 4'(i) || digit_index !== 3'(i)) begin
          errors++;
          $display("FAIL win_step%0d: got correct=%0d idx=%0d, expected %0d %0d",
                   i, correct_count, digit_index, i, i);
        end
      end
    end
    tick();
    checks++;
    if (round_done !== 1'b0 || round_win !== 1'b1 || correct_count !== 4'd8 ||
        miss_count !== 2'd0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL win_done_hold: got done=%b win=%b correct=%0d miss=%0d playing=%b, expected 0 1 8 0 0",
               round_done, round_win, correct_count, miss_count, playing);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL win_scoreboard: got %0d pending rounds, expected 0", exp_q.size());
    end
  endtask

  task automatic test_fail();
    do_start();
    checks++;
    if (correct_count !== 4'd0 || round_win !== 1'b0 || change_answer !== 1'b1) begin
      errors++;
      $display("FAIL fail_restart_clear: got correct=%0d win=%b change=%b, expected 0 0 1",
               correct_count, round_win, change_answer);
    end
    exp_q.push_back('{win: 1'b0, fail: 1'b1, correct: 4'd0, miss: 2'd3});
    give_answer(32'h1111_1111);
    guess(4'd9);
    guess(4'd0);
    checks++;
    if (miss_count !== 2'd0 || correct_count !== 4'd0) begin
      errors++;
      $display("FAIL fail_out_of_range: got miss=%0d correct=%0d, expected 0 0", miss_count, correct_count);
    end
    guess(4'd2);
    guess(4'd3);
    checks++;
    if (miss_count !== 2'd2 || playing !== 1'b1) begin
      errors++;
      $display("FAIL fail_two_misses: got miss=%0d playing=%b, expected 2 1", miss_count, playing);
    end
    guess(4'd4);
    checks++;
    if (miss_count !== 2'd3 || round_fail !== 1'b1 || round_win !== 1'b0 ||
        digit_index !== 3'd0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL fail_final: got miss=%0d fail=%b win=%b idx=%0d playing=%b, expected 3 1 0 0 0",
               miss_count, round_fail, round_win, digit_index, playing);
    end
  endtask

  task automatic test_invalid_answer();
    do_start();
    tick();
    give_answer(32'h1230_5678);
    checks++;
    if (playing !== 1'b0 || change_answer !== 1'b1) begin
      errors++;
      $display("FAIL invalid_repulse: got playing=%b change=%b, expected 0 1", playing, change_answer);
    end
    tick();
    give_answer(32'h8888_8888);
    checks++;
    if (playing !== 1'b1) begin
      errors++;
      $display("FAIL invalid_then_valid: got playing=%b, expected 1", playing);
    end
  endtask

  task automatic test_stray_enable();
    give_answer(32'h1234_5678);
    guess(4'd8);
    checks++;
    if (correct_count !== 4'd1 || miss_count !== 2'd0) begin
      errors++;
      $display("FAIL stray_enable: got correct=%0d miss=%0d, expected 1 0", correct_count, miss_count);
    end
  endtask

  task automatic test_timeout();
    int seen;
    do_start();
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (change_answer === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d pulses in 15 cycles, expected 0", seen);
    end
    tick();
    checks++;
    if (change_answer !== 1'b1 || playing !== 1'b0) begin
      errors++;
      $display("FAIL timeout_repulse: got change=%b playing=%b, expected 1 0", change_answer, playing);
    end
    give_answer(32'h5656_5656);
  endtask

  task automatic test_abort_and_reset();
    guess(4'd5);
    start       = 1'b1;
    guess_valid = 1'b1;
    guess_digit = 4'd6;
    tick();
    start       = 1'b0;
    guess_valid = 1'b0;
    checks++;
    if (playing !== 1'b0 || change_answer !== 1'b1 || correct_count !== 4'd0 ||
        digit_index !== 3'd0 || miss_count !== 2'd0) begin
      errors++;
      $display("FAIL abort: got playing=%b change=%b correct=%0d idx=%0d miss=%0d, expected 0 1 0 0 0",
               playing, change_answer, correct_count, digit_index, miss_count);
    end
    give_answer(32'h5656_5656);
    guess(4'd5);
    guess(4'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({change_answer, playing, digit_index, correct_count, miss_count,
         round_done, round_win, round_fail, hint_high} !== 15'd0) begin
      errors++;
      $display("FAIL reset_midplay: got %b, expected all zero",
               {change_answer, playing, digit_index, correct_count, miss_count,
                round_done, round_win, round_fail, hint_high});
    end
    do_start();
    rst          = 1'b1;
    write_enable = 1'b1;
    answer_in    = 32'h1234_5678;
    tick();
    rst          = 1'b0;
    write_enable = 1'b0;
    tick();
    tick();
    checks++;
    if (playing !== 1'b0 || change_answer !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_enable: got playing=%b change=%b, expected 0 0", playing, change_answer);
    end
  endtask

  task automatic test_hint();
    do_start();
    give_answer(32'h5555_5555);
    guess(4'd3);
    checks++;
    if (hint_high !== HINT_EN || miss_count !== 2'd1) begin
      errors++;
      $display("FAIL hint_low_guess: got hint=%b miss=%0d, expected %b 1", hint_high, miss_count, HINT_EN);
    end
    guess(4'd7);
    checks++;
    if (hint_high !== 1'b0 || miss_count !== 2'd2) begin
      errors++;
      $display("FAIL hint_high_guess: got hint=%b miss=%0d, expected 0 2", hint_high, miss_count);
    end
    guess(4'd5);
    checks++;
    if (hint_high !== 1'b0 || correct_count !== 4'd1) begin
      errors++;
      $display("FAIL hint_after_hit: got hint=%b correct=%0d, expected 0 1", hint_high, correct_count);
    end
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    write_enable = 1'b0;
    answer_in    = '0;
    guess_valid  = 1'b0;
    guess_digit  = '0;
    test_reset();
    test_win();
    test_fail();
    test_invalid_answer();
    test_stray_enable();
    test_timeout();
    test_abort_and_reset();
    test_hint();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard: got %0d pending rounds, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/answer_checker.md
Name: answer_checker

Overview:
- Consumer end of the answer-generator handshake for the digit-guessing game.
- Requests a fresh answer by pulsing change_answer, latches the 8-digit answer word when write_enable arrives, then scores the player's guesses one digit at a time.
- Sits between the answer generator and the button/display logic.

Parameters:
DIGITS, 8, number of 4-bit digits in the answer word
MAX_MISS, 3, wrong guesses allowed before the round fails
REQ_TIMEOUT, 16, cycles to wait in REQ for write_enable before re-pulsing change_answer

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin a new round
write_enable  input  1  one-cycle pulse from generator: answer_in valid
answer_in  input  4*DIGITS  answer word; digit 0 = bits [31:28], MSB-first
guess_valid  input  1  one-cycle pulse: guess_digit valid
guess_digit  input  4  player digit, legal 1..8
change_answer  output  1  one-cycle request pulse to generator
playing  output  1  high while in PLAY
digit_index  output  3  index of the digit currently expected
correct_count  output  4  digits matched this round
miss_count  output  2  wrong guesses this round
round_done  output  1  one-cycle pulse on entering DONE
round_win  output  1  level; valid in DONE
round_fail  output  1  level; valid in DONE
hint_high  output  1  see Optional Feature

Behaviour:
- Reset: state IDLE. All outputs 0. Latched answer cleared to 0.
- States: IDLE, REQ, PLAY, DONE.
- IDLE/DONE + start → REQ.
  - change_answer asserted for exactly the first REQ cycle.
  - All counters, digit_index, round_win and round_fail cleared on that transition.
- REQ:
  - write_enable latches answer_in.
  - If every nibble is in 1..8: go to PLAY next cycle.
  - Otherwise: stay in REQ, reset the timeout counter, pulse change_answer again next cycle.
  - If REQ_TIMEOUT cycles pass with no write_enable: re-pulse change_answer and restart the count.
- write_enable outside REQ: ignored, answer unchanged.
- PLAY, guess_valid with guess_digit outside 1..8: ignored, no count change.
- PLAY, guess equals answer digit[digit_index]:
  - correct_count++ and digit_index++ (registered, visible next cycle).
  - If digit_index was DIGITS-1: go to DONE, round_win=1.
- PLAY, mismatch:
  - miss_count++ and digit_index unchanged (player retries the same digit).
  - If miss_count becomes MAX_MISS: go to DONE, round_fail=1.
- round_done pulses for 1 cycle, in the first DONE cycle.
- DONE holds all outputs until start.
- start in PLAY aborts the round → REQ. A guess in the same cycle is discarded.
- start in REQ: ignored.
- rst mid-round: returns to IDLE next edge with reset values. An in-flight write_enable is dropped.
- Latency: guess in cycle N → counters, index and state updated at edge N+1.
- Widths:
  - correct_count saturates at DIGITS.
  - digit_index width is clog2(DIGITS).
  - Guesses are compared as 4-bit unsigned values.

Optional Feature:
- Macro ANSWER_CHECKER_HINT_EN.
- Defined: on each counted mismatch, hint_high is registered as 1 if answer digit > guess_digit, else 0. It holds until the next counted guess or start.
- Undefined: hint_high is tied to 0. No comparator logic is built.

Decomposition:
- Package game_pkg holds:
  - DIGIT_W=4, DIGIT_MIN=1, DIGIT_MAX=8.
  - state enum {IDLE, REQ, PLAY, DONE}.
  - function digit_ok(nibble), returning whether the nibble is in range.
- Sub-module digit_select: combinational mux returning answer nibble [index] with MSB-first ordering. It is shared with display logic.
- FSM and counters stay in answer_checker.

Test Plan:
- Normal win:
  - Stimulus: rst, then start; check change_answer pulses exactly once. Drive write_enable with answer_in=0x12345678, then guesses 1..8.
  - Response: correct_count=8, round_win=1, round_done single pulse, miss_count=0.
- Fail:
  - Stimulus: answer 0x11111111; guesses 2, 3, 4.
  - Response: miss_count=3, round_fail=1, digit_index=0, round_win=0.
- Invalid answer:
  - Stimulus: write_enable with 0x12305678.
  - Response: stays in REQ, change_answer re-pulses next cycle. Then 0x88888888 enters PLAY.
- Timeout and stray enable:
  - Stimulus: write_enable pulse in PLAY; no write_enable for 16 cycles in REQ.
  - Response: the PLAY pulse leaves the answer unchanged; the REQ timeout re-pulses change_answer.
- Abort and reset:
  - Stimulus: start together with guess_valid mid-PLAY; separately, rst mid-PLAY.
  - Response: the guess is not counted and the block enters REQ. rst gives IDLE with all outputs 0.
- Hint (with ANSWER_CHECKER_HINT_EN):
  - Stimulus: answer digit 5, guess 3.
  - Response: hint_high=1. A following guess of 7 gives hint_high=0. Without the macro, hint_high is always 0.
